// File: rtl/s2p_rr_sched.sv
// s2p_rr_sched: round-robin arbiter sharing one serial-to-parallel
// deserializer among N_CH serial requesters. Frames the deserializer enable
// for W+1 cycles per word, captures the parallel word and returns it tagged
// with its channel index on a valid/ready port.
// Optional feature macro: S2P_RR_LOCK_EN (lock-based regrant of the channel
// just served, ahead of round-robin order).
module s2p_rr_sched #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned PORT_WIDTH = 8,
    parameter int unsigned CH_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH-1:0]       si,
    input  logic [N_CH-1:0]       lock,
    output logic [N_CH-1:0]       gnt,
    output logic                  s2p_si,
    output logic                  s2p_dat_en,
    input  logic [PORT_WIDTH-1:0] s2p_po,
    output logic [PORT_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CNT_W = $clog2(PORT_WIDTH + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [CH_W-1:0]       ptr;
    logic [CH_W-1:0]       ptr_nxt;
    logic [CH_W-1:0]       cur;
    logic [CH_W-1:0]       cur_nxt;
    logic [N_CH-1:0]       gnt_nxt;
    logic                  en_nxt;
    logic [PORT_WIDTH-1:0] out_data_nxt;
    logic [CH_W-1:0]       out_ch_nxt;
    logic                  out_valid_nxt;

    logic                  arb_any;
    logic [CH_W-1:0]       arb_win;
    logic [CH_W-1:0]       cand;

`ifndef S2P_RR_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Only the granted line reaches the deserializer; zero when nothing is granted.
    assign s2p_si = |(si & gnt);

    // Round-robin search starting at the channel after the last winner.
    always_comb begin
        arb_any = 1'b0;
        arb_win = '0;
        cand    = '0;
        for (int i = 1; i <= int'(N_CH); i++) begin
            cand = CH_W'((int'(ptr) + i) % int'(N_CH));
            if (!arb_any && req[cand]) begin
                arb_any = 1'b1;
                arb_win = cand;
            end
        end
    end

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ptr_nxt       = ptr;
        cur_nxt       = cur;
        gnt_nxt       = gnt;
        en_nxt        = s2p_dat_en;
        out_data_nxt  = out_data;
        out_ch_nxt    = out_ch;
        out_valid_nxt = out_valid;

        case (state)
            IDLE: begin
                if (arb_any) begin
                    gnt_nxt          = '0;
                    gnt_nxt[arb_win] = 1'b1;
                    en_nxt           = 1'b1;
                    cnt_nxt          = '0;
                    ptr_nxt          = arb_win;
                    cur_nxt          = arb_win;
                    state_nxt        = SHIFT;
                end
            end
            SHIFT: begin
                cnt_nxt = cnt + CNT_W'(1);
                // Cycle W is the dummy cycle in which the deserializer loads po.
                if (cnt == CNT_W'(PORT_WIDTH)) begin
                    gnt_nxt   = '0;
                    en_nxt    = 1'b0;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                out_data_nxt  = s2p_po;
                out_ch_nxt    = cur;
                out_valid_nxt = 1'b1;
                state_nxt     = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
`ifdef S2P_RR_LOCK_EN
                    if (lock[cur] && req[cur]) begin
                        gnt_nxt      = '0;
                        gnt_nxt[cur] = 1'b1;
                        en_nxt       = 1'b1;
                        cnt_nxt      = '0;
                        state_nxt    = SHIFT;
                    end else
`endif
                    if (arb_any) begin
                        gnt_nxt          = '0;
                        gnt_nxt[arb_win] = 1'b1;
                        en_nxt           = 1'b1;
                        cnt_nxt          = '0;
                        ptr_nxt          = arb_win;
                        cur_nxt          = arb_win;
                        state_nxt        = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                en_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the enable so no partial word survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= CH_W'(N_CH - 1);
            cur        <= '0;
            gnt        <= '0;
            s2p_dat_en <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ptr        <= ptr_nxt;
            cur        <= cur_nxt;
            gnt        <= gnt_nxt;
            s2p_dat_en <= en_nxt;
            out_data   <= out_data_nxt;
            out_ch     <= out_ch_nxt;
            out_valid  <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_s2p_rr_sched.sv
// Directed bench for s2p_rr_sched with a behavioural deserializer and
// per-channel serial requesters that shift out a stored word LSB-first.
module tb_s2p_rr_sched;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned CH_W = 2;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] si;
    logic [N_CH-1:0] lock;
    logic [N_CH-1:0] gnt;
    logic            s2p_si;
    logic            s2p_dat_en;
    logic [W-1:0]    s2p_po;
    logic [W-1:0]    out_data;
    logic [CH_W-1:0] out_ch;
    logic            out_valid;
    logic            out_ready;

    logic [W-1:0]    words [N_CH];
    logic [3:0]      bp    [N_CH];
    logic [W-1:0]    ds_sh;
    logic [3:0]      ds_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    s2p_rr_sched #(.N_CH(N_CH), .PORT_WIDTH(W), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .si        (si),
        .lock      (lock),
        .gnt       (gnt),
        .s2p_si    (s2p_si),
        .s2p_dat_en(s2p_dat_en),
        .s2p_po    (s2p_po),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters: present bit k during the k-th granted cycle.
    for (genvar c = 0; c < N_CH; c++) begin : g_req
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) bp[c] <= 4'd0;
            else        bp[c] <= gnt[c] ? bp[c] + 4'd1 : 4'd0;
        end
        assign si[c] = (bp[c] < 4'd8) ? words[c][bp[c][2:0]] : 1'b0;
    end

    // Deserializer: bits on enabled edges 0..W-1, load po on edge W, clear when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_sh  <= '0;
            ds_cnt <= 4'd0;
            s2p_po <= '0;
        end else if (s2p_dat_en) begin
            if (ds_cnt < 4'd8) begin
                ds_sh[ds_cnt[2:0]] <= s2p_si;
                ds_cnt             <= ds_cnt + 4'd1;
            end else begin
                s2p_po <= ds_sh;
            end
        end else begin
            ds_cnt <= 4'd0;
            s2p_po <= '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [W-1:0]    exp_w;
    logic [CH_W-1:0] ch_e;
    logic [CH_W-1:0] lk_seq [3];

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        lock      = '0;
        out_ready = 1'b1;
        words[0]  = 8'h00;
        words[1]  = 8'h00;
        words[2]  = 8'h00;
        words[3]  = 8'h00;

        // Reset state
        step(2);
        check("rst_gnt",   32'(gnt), 32'h0);
        check("rst_si",    32'(s2p_si), 32'h0);
        check("rst_en",    32'(s2p_dat_en), 32'h0);
        check("rst_data",  32'(out_data), 32'h0);
        check("rst_ch",    32'(out_ch), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Single word from channel 2
        exp_w    = 8'hA5;
        words[2] = exp_w;
        req      = 4'b0100;
        step(1);
        check("sw_gnt_c1", 32'(gnt), 32'h4);
        check("sw_en_c1",  32'(s2p_dat_en), 32'h1);
        check("sw_si_b0",  32'(s2p_si), 32'(exp_w[0]));
        req = 4'b0000;
        for (int k = 2; k <= 9; k++) begin
            step(1);
            check("sw_gnt", 32'(gnt), 32'h4);
            if (k <= 8) check("sw_si", 32'(s2p_si), 32'(exp_w[3'(k - 1)]));
        end
        step(1);
        check("sw_cap_gnt",   32'(gnt), 32'h0);
        check("sw_cap_en",    32'(s2p_dat_en), 32'h0);
        check("sw_cap_valid", 32'(out_valid), 32'h0);
        step(1);
        check("sw_valid", 32'(out_valid), 32'h1);
        check("sw_data",  32'(out_data), 32'hA5);
        check("sw_ch",    32'(out_ch), 32'h2);
        step(1);
        check("sw_done_valid", 32'(out_valid), 32'h0);
        check("sw_done_gnt",   32'(gnt), 32'h0);

        // Round-robin from reset pointer: 0,1,2,3,0 every 11 cycles
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        words[0] = 8'h81;
        words[1] = 8'h42;
        words[2] = 8'h24;
        words[3] = 8'h18;
        req = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            step(11);
            ch_e = 2'(w % 4);
            check("rr_valid", 32'(out_valid), 32'h1);
            check("rr_ch",    32'(out_ch), 32'(ch_e));
            check("rr_data",  32'(out_data), 32'(words[ch_e]));
        end
        req = 4'b0000;
        step(1);
        check("rr_idle_valid", 32'(out_valid), 32'h0);

        // Backpressure: output frozen, no grant while out_ready is low
        out_ready = 1'b0;
        words[1]  = 8'hC3;
        req       = 4'b0010;
        step(11);
        check("bp_valid", 32'(out_valid), 32'h1);
        check("bp_data",  32'(out_data), 32'hC3);
        check("bp_ch",    32'(out_ch), 32'h1);
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("bp_hold", 32'({out_valid, out_data, out_ch, gnt}),
                  32'({1'b1, 8'hC3, 2'd1, 4'b0000}));
        end
        out_ready = 1'b1;
        step(1);
        check("bp_next_gnt",   32'(gnt), 32'h4);
        check("bp_next_valid", 32'(out_valid), 32'h0);
        req = 4'b0000;
        step(10);
        check("bp2_valid", 32'(out_valid), 32'h1);
        check("bp2_ch",    32'(out_ch), 32'h2);
        check("bp2_data",  32'(out_data), 32'h24);
        step(1);

        // Reset asserted at bit 4 of a channel-3 frame
        req = 4'b1000;
        step(1);
        check("mr_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        step(4);
        rst_n = 1'b0;
        #1;
        check("mr_gnt0",   32'(gnt), 32'h0);
        check("mr_en0",    32'(s2p_dat_en), 32'h0);
        check("mr_si0",    32'(s2p_si), 32'h0);
        check("mr_valid0", 32'(out_valid), 32'h0);
        check("mr_data0",  32'(out_data), 32'h0);
        check("mr_ch0",    32'(out_ch), 32'h0);
        step(2);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step(1);
            check("mr_quiet", 32'({out_valid, gnt}), 32'h0);
        end
        words[0] = 8'h96;
        req      = 4'b0001;
        step(1);
        check("mr_fresh_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step(10);
        check("mr_fresh_valid", 32'(out_valid), 32'h1);
        check("mr_fresh_data",  32'(out_data), 32'h96);
        check("mr_fresh_ch",    32'(out_ch), 32'h0);
        step(1);

        // Request dropped at bit 3: word still completes
        words[1] = 8'h5C;
        req      = 4'b0010;
        step(1);
        check("rd_gnt", 32'(gnt), 32'h2);
        step(3);
        req = 4'b0000;
        step(7);
        check("rd_valid", 32'(out_valid), 32'h1);
        check("rd_ch",    32'(out_ch), 32'h1);
        check("rd_data",  32'(out_data), 32'h5C);
        step(1);

        // Lock on channel 3 with channels 0 and 3 requesting
`ifdef S2P_RR_LOCK_EN
        lk_seq[0] = 2'd3;
        lk_seq[1] = 2'd3;
        lk_seq[2] = 2'd0;
`else
        lk_seq[0] = 2'd3;
        lk_seq[1] = 2'd0;
        lk_seq[2] = 2'd3;
`endif
        words[3] = 8'hE7;
        words[0] = 8'h0F;
        lock     = 4'b1000;
        req      = 4'b1001;
        for (int w = 0; w < 3; w++) begin
            step(11);
            check("lk_valid", 32'(out_valid), 32'h1);
            check("lk_ch",    32'(out_ch), 32'(lk_seq[w]));
            check("lk_data",  32'(out_data), 32'(words[lk_seq[w]]));
            if (w == 1) lock = 4'b0000;
        end
        req = 4'b0000;
        step(1);
        check("lk_end_valid", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
